hack_cpu_ctrl: RTL
==================

Name: hack_cpu_ctrl

Overview:
Multi-cycle HACK instruction sequencer and the consumer side of the HACK ALU interface.
- Fetches 16-bit instructions and holds the A, D, PC and IR registers.
- Drives the ALU operands and the 6-bit control word, then samples out/zr/ng to commit destinations and resolve jumps.
- Talks to instruction and data memory through req/ack handshakes, so wait-state memories work unchanged.

Parameters:
RESET_PC, 15'h0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
imem_req  out  1  instruction fetch request.
imem_addr  out  15  fetch address (= PC).
imem_data  in  16  instruction word, valid with imem_ack.
imem_ack  in  1  fetch complete.
dmem_rd  out  1  data read request.
dmem_wr  out  1  data write request.
dmem_addr  out  15  data address (= A[14:0]).
dmem_wdata  out  16  write data (= latched ALU result R).
dmem_rdata  in  16  read data, valid with dmem_ack.
dmem_ack  in  1  data transfer complete.
alu_x  out  16  ALU x operand (= D).
alu_y  out  16  ALU y operand (M-latch if IR[12], else A).
alu_ctl  out  6  ALU control {zx,nx,zy,ny,f,no} = IR[11:6].
alu_out  in  16  ALU result (combinational, same cycle).
alu_zr  in  1  ALU zero flag.
alu_ng  in  1  ALU negative flag.
pc  out  15  current PC (debug).
a_reg  out  16  A register (debug).
d_reg  out  16  D register (debug).
instr_done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- The interface is one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async, immediate): PC=RESET_PC, A=0, D=0, IR=0, M-latch=0, R=0, state=FETCH, instr_done=0.
  - imem_req, dmem_rd and dmem_wr are forced to 0 while rst is high.
  - Reset mid-transfer drops the request at once. A late ack is ignored.
- FSM states: FETCH, DECODE, MEMRD, EXEC, MWRITE. Request outputs are decoded from state.
- FETCH:
  - imem_req=1, imem_addr=PC, both held stable until imem_ack.
  - On ack: IR<=imem_data, go to DECODE.
- DECODE:
  - IR[15]=0 (A-instr): A<={0,IR[14:0]}, PC<=PC+1, instr_done pulse, go to FETCH.
  - IR[15]=1 and IR[12]=1: go to MEMRD.
  - Otherwise: go to EXEC.
  - IR[14:13] are ignored.
- MEMRD:
  - dmem_rd=1, dmem_addr=A[14:0], held until dmem_ack.
  - On ack: M-latch<=dmem_rdata, go to EXEC.
- EXEC (one cycle):
  - ALU driven as above. R<=alu_out.
  - Jump decision: take = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - If IR[4]: D<=alu_out.
  - If IR[3]: latch take, go to MWRITE. A and PC stay unchanged.
  - Else: if IR[5], A<=alu_out. PC<=take ? A_old[14:0] : PC+1. instr_done pulse. Go to FETCH.
- MWRITE:
  - dmem_wr=1, dmem_addr=A_old[14:0], dmem_wdata=R, held until dmem_ack.
  - On ack: A update if IR[5], PC update with the latched take, instr_done pulse, go to FETCH.
- Jump target and M address always use A as it was before this instruction's A destination write.
- PC increment wraps 15'h7FFF -> 0.
- Acks are sampled only in their matching state. Acks at other times have no effect.
- dmem_rd and dmem_wr are never high together. imem_req is never high together with either.
- Zero-wait cycle counts, including retire:
  - A-instr: 2 cycles.
  - C-instr: 3 cycles.
  - +1 cycle if a=1.
  - +1 cycle if d3=1.
  - Each wait cycle adds 1.

Test Plan:
- Reset then "@5" (0x0005), zero-wait memory -> imem_addr=0. a_reg=0x0005 after 2 cycles. pc=1. One instr_done pulse.
- A=5, D=3, instr 0xE090 (D=D+A, comp 000010, d=010) -> d_reg=8, pc advances by 1, no dmem activity. 3 cycles.
- A=7, D=0x0102, instr 0xE308 (M=D, comp 001100, d=001) -> dmem_wr with addr=7, wdata=0x0102 held through 3 wait cycles. Retire only after ack.
- A=10, M[10]=0xFFFF, instr 0xFC10 (D=M) -> dmem_rd addr=10, then d_reg=0xFFFF.
- D=0, A=0x0020, instr 0xE302 (D;JEQ) -> pc=0x0020. Same with D=1 -> pc+1.
- Assert rst during MEMRD with ack arriving 1 cycle later -> dmem_rd drops immediately. pc=RESET_PC, regs zero, next fetch at 0.

Source files
------------

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle HACK instruction sequencer: owns A/D/PC/IR, drives an external ALU
// and talks to instruction/data memories through req/ack handshakes.
`timescale 1ns/1ps

module hack_cpu_ctrl #(
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_ack,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic        instr_done
);

    typedef enum logic [2:0] {FETCH, DECODE, MEMRD, EXEC, MWRITE} state_t;

    state_t      state, state_next;
    logic [15:0] ir, a_q, d_q, m_latch, r_q;
    logic [14:0] pc_q, pc_inc;
    logic        take, take_q, done_q, retire;

    assign pc_inc = pc_q + 15'd1;
    assign take   = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            FETCH:  if (imem_ack) state_next = DECODE;
            DECODE: begin
                if (!ir[15]) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end else if (ir[12]) begin
                    state_next = MEMRD;
                end else begin
                    state_next = EXEC;
                end
            end
            MEMRD:  if (dmem_ack) state_next = EXEC;
            EXEC: begin
                if (ir[3]) begin
                    state_next = MWRITE;
                end else begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            MWRITE: begin
                if (dmem_ack) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // A and PC only change at retire, so dmem_addr and the jump target keep the old A
    // throughout MWRITE; the deferred A write therefore comes from R, not the live ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            a_q     <= 16'h0000;
            d_q     <= 16'h0000;
            ir      <= 16'h0000;
            m_latch <= 16'h0000;
            r_q     <= 16'h0000;
            take_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= retire;
            case (state)
                FETCH:  if (imem_ack) ir <= imem_data;
                DECODE: begin
                    if (!ir[15]) begin
                        a_q  <= {1'b0, ir[14:0]};
                        pc_q <= pc_inc;
                    end
                end
                MEMRD:  if (dmem_ack) m_latch <= dmem_rdata;
                EXEC: begin
                    r_q <= alu_out;
                    if (ir[4]) d_q <= alu_out;
                    if (ir[3]) begin
                        take_q <= take;
                    end else begin
                        if (ir[5]) a_q <= alu_out;
                        pc_q <= take ? a_q[14:0] : pc_inc;
                    end
                end
                MWRITE: begin
                    if (dmem_ack) begin
                        if (ir[5]) a_q <= r_q;
                        pc_q <= take_q ? a_q[14:0] : pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = !rst && (state == FETCH);
    assign dmem_rd    = !rst && (state == MEMRD);
    assign dmem_wr    = !rst && (state == MWRITE);
    assign imem_addr  = pc_q;
    assign dmem_addr  = a_q[14:0];
    assign dmem_wdata = r_q;
    assign alu_x      = d_q;
    assign alu_y      = ir[12] ? m_latch : a_q;
    assign alu_ctl    = ir[11:6];
    assign pc         = pc_q;
    assign a_reg      = a_q;
    assign d_reg      = d_q;
    assign instr_done = done_q;

endmodule
